mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Unified 2^AW x 8 program/data memory and bus controller sitting directly downstream of the cpu
//  control unit: it consumes En/Rw plus the address/data bus, and returns read data to IReg/Acc/PC muxes.
//  Also contains a byte-stream program loader that fills memory while the cpu is held (pause/reset),
//  with an address counter, valid/ready handshake and running 8-bit checksum.
// PARAMETERS
//  AW        8     address width; depth = 2**AW bytes
//  LOAD_LEN  256   bytes per load session (1..2**AW); session ends after this many accepted bytes
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  rst         in   1   asynchronous active-low reset
//  En          in   1   cpu memory access strobe (one access per cycle with En=1)
//  Rw          in   1   1 = read, 0 = write (sampled only when En=1)
//  addr        in   AW  address bus (driven by cpu buffer selects)
//  wdata       in   8   write data (Acc via bus)
//  rdata       out  8   registered read data, valid 1 cycle after a read access
//  rvalid      out  1   1-cycle pulse aligned with new rdata
//  ld_mode     in   1   1 = loader owns memory (cpu held by system); level signal
//  ld_valid    in   1   loader byte available
//  ld_data     in   8   loader byte
//  ld_ready    out  1   controller can accept a loader byte this cycle
//  ld_done     out  1   session complete (sticky until ld_mode falls)
//  ld_csum     out  8   mod-256 sum of bytes accepted in current/last session
//  bus_err     out  1   sticky: cpu En=1 seen while ld_mode=1; cleared only by reset
// BEHAVIOUR
//  Reset (rst=0, async): rdata=0, rvalid=0, ld_ready=0, ld_done=0, ld_csum=0, bus_err=0,
//   loader FSM -> L_IDLE, load address counter=0. Memory contents NOT cleared.
//  CPU path (ld_mode=0): En=1,Rw=1 -> rdata<=mem[addr], rvalid=1 next cycle (latency 1).
//   En=1,Rw=0 -> mem[addr]<=wdata at this edge; rdata holds; rvalid=0.
//   Read same address as write in following cycle returns new data. En=0 -> rdata holds, rvalid=0.
//  CPU access while ld_mode=1: ignored (no read, no write, rvalid=0), bus_err<=1.
//  Loader FSM states:
//   L_IDLE : ld_ready=0. ld_mode rising (0->1) -> L_LOAD, counter<=0, ld_csum<=0, ld_done<=0.
//   L_LOAD : ld_ready=1. ld_valid&ld_ready -> mem[counter]<=ld_data, ld_csum<=ld_csum+ld_data
//            (8-bit wrap), counter<=counter+1. When accepted byte is number LOAD_LEN -> L_DONE.
//            ld_mode falls -> L_IDLE (partial load kept, ld_done stays 0).
//   L_DONE : ld_ready=0, ld_done=1, further ld_valid ignored. ld_mode falls -> L_IDLE, ld_done<=0.
//  Counter wraps 2**AW-1 -> 0 only if LOAD_LEN=2**AW (last accept then exits to L_DONE anyway).
//  ld_valid while ld_ready=0: no effect, byte not consumed (source must hold).
//  ld_mode rising and ld_valid same cycle: byte not accepted (ld_ready still 0 that cycle).
//  ld_csum frozen outside L_LOAD; readable after session for host comparison.
//  Reset mid-load: FSM -> L_IDLE immediately; bytes already written remain in memory.
//  Single write port: loader and cpu never write same cycle (cpu gated by ld_mode).
// TESTING
//  T1 cpu write/read: En=1,Rw=0,addr=0x10,wdata=0xA5; next cycle En=1,Rw=1,addr=0x10 -> cycle after: rdata=0xA5, rvalid=1.
//  T2 load session LOAD_LEN=4: ld_mode=1, stream 0x61,0x0F,0x70,0x20 -> mem[0..3] match, ld_done=1, ld_csum=0x00 (0x100 wrapped).
//  T3 backpressure: ld_valid held 3 cycles during L_DONE -> ld_ready=0, memory and ld_csum unchanged.
//  T4 conflict: ld_mode=1, cpu En=1,Rw=0,addr=0x00,wdata=0xFF -> mem[0] unchanged, rvalid=0, bus_err=1 until reset.
//  T5 abort: ld_mode drops after 2 of 4 bytes -> L_IDLE, ld_done=0, mem[0..1] written, ld_csum = sum of 2 bytes.
//  T6 async reset mid-load: rst=0 between clock edges -> ld_ready/ld_done/ld_csum=0 before next edge; re-raise ld_mode restarts at addr 0.

Source files
------------

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - unified byte memory with cpu bus port and streaming program loader
module mem_ctrl #(
   parameter int AW       = 8,
   parameter int LOAD_LEN = 256
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          En,
   input  logic          Rw,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata,
   output logic          rvalid,
   input  logic          ld_mode,
   input  logic          ld_valid,
   input  logic [7:0]    ld_data,
   output logic          ld_ready,
   output logic          ld_done,
   output logic [7:0]    ld_csum,
   output logic          bus_err
);

   localparam logic [AW:0] LEN = (AW+1)'(LOAD_LEN);

   typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE} ld_state_t;

   ld_state_t     state, next_state;
   logic [7:0]    mem [0:(2**AW)-1];
   logic [AW-1:0] counter;
   logic          ld_mode_q;
   logic          ld_rise;
   logic          ld_accept;
   logic          ld_last;
   logic          cpu_rd;
   logic          cpu_wr;

   // The cpu is locked out whenever the loader owns memory, so the two never share the write port.
   assign cpu_rd    = En && Rw && !ld_mode;
   assign cpu_wr    = En && !Rw && !ld_mode;
   assign ld_rise   = ld_mode && !ld_mode_q;
   assign ld_accept = ld_valid && ld_ready;
   assign ld_last   = ({1'b0, counter} + (AW+1)'(1)) == LEN;

   always_comb begin
      next_state = state;
      ld_ready   = 1'b0;
      ld_done    = 1'b0;
      case (state)
         L_IDLE: begin
            if (ld_rise) next_state = L_LOAD;
         end
         L_LOAD: begin
            ld_ready = ld_mode;
            if (!ld_mode)                 next_state = L_IDLE;
            else if (ld_accept && ld_last) next_state = L_DONE;
         end
         L_DONE: begin
            ld_done = 1'b1;
            if (!ld_mode) next_state = L_IDLE;
         end
         default: next_state = L_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= L_IDLE;
         ld_mode_q <= 1'b0;
         counter   <= '0;
         ld_csum   <= 8'h00;
         rdata     <= 8'h00;
         rvalid    <= 1'b0;
         bus_err   <= 1'b0;
      end else begin
         state     <= next_state;
         ld_mode_q <= ld_mode;
         if (state == L_IDLE && ld_rise) begin
            counter <= '0;
            ld_csum <= 8'h00;
         end else if (ld_accept) begin
            counter <= counter + AW'(1);
            ld_csum <= ld_csum + ld_data;
         end
         rvalid <= cpu_rd;
         if (cpu_rd) rdata <= mem[addr];
         if (En && ld_mode) bus_err <= 1'b1;
      end
   end

   // Contents survive reset, so the array has no reset branch.
   always_ff @(posedge clk) begin
      if (ld_accept)   mem[counter] <= ld_data;
      else if (cpu_wr) mem[addr]    <= wdata;
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
module tb_mem_ctrl;

   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          En, Rw;
   logic [AW-1:0] addr;
   logic [7:0]    wdata, rdata;
   logic          rvalid;
   logic          ld_mode, ld_valid, ld_ready, ld_done, bus_err;
   logic [7:0]    ld_data, ld_csum;

   int checks = 0;
   int errors = 0;

   logic [7:0] t2_bytes [4] = '{8'h61, 8'h0F, 8'h70, 8'h20};

   mem_ctrl #(.AW(AW), .LOAD_LEN(4)) dut (
      .clk(clk), .rst(rst), .En(En), .Rw(Rw), .addr(addr), .wdata(wdata),
      .rdata(rdata), .rvalid(rvalid), .ld_mode(ld_mode), .ld_valid(ld_valid),
      .ld_data(ld_data), .ld_ready(ld_ready), .ld_done(ld_done),
      .ld_csum(ld_csum), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
      En = 1'b1; Rw = 1'b0; addr = a; wdata = d;
      tick();
      En = 1'b0;
      check("wr_rvalid", {7'd0, rvalid}, 8'h00);
   endtask

   task automatic cpu_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
      En = 1'b1; Rw = 1'b1; addr = a;
      tick();
      En = 1'b0;
      check({tag, "_rvalid"}, {7'd0, rvalid}, 8'h01);
      check(tag, rdata, exp);
   endtask

   task automatic send(input logic [7:0] d);
      ld_valid = 1'b1; ld_data = d;
      tick();
      ld_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b0; En = 1'b0; Rw = 1'b0; addr = '0; wdata = '0;
      ld_mode = 1'b0; ld_valid = 1'b0; ld_data = '0;
      #3;
      check("rst_rdata", rdata, 8'h00);
      check("rst_rvalid", {7'd0, rvalid}, 8'h00);
      check("rst_ready", {7'd0, ld_ready}, 8'h00);
      check("rst_done", {7'd0, ld_done}, 8'h00);
      check("rst_csum", ld_csum, 8'h00);
      check("rst_buserr", {7'd0, bus_err}, 8'h00);
      tick(); tick();
      rst = 1'b1;
      tick();

      // T1: cpu write then read back
      cpu_write(8'h10, 8'hA5);
      cpu_write(8'h04, 8'h33);
      cpu_read("t1_rd", 8'h10, 8'hA5);
      tick();
      check("t1_rvalid_drop", {7'd0, rvalid}, 8'h00);
      check("t1_rdata_hold", rdata, 8'hA5);

      // T2: four-byte session; first byte offered on the rising cycle is not taken
      ld_mode = 1'b1; ld_valid = 1'b1; ld_data = 8'h61;
      check("t2_ready_idle", {7'd0, ld_ready}, 8'h00);
      tick();
      check("t2_ready_load", {7'd0, ld_ready}, 8'h01);
      check("t2_csum_start", ld_csum, 8'h00);
      for (int i = 0; i < 4; i++) begin
         ld_valid = 1'b1; ld_data = t2_bytes[i];
         tick();
         if (i == 1) check("t2_csum_mid", ld_csum, 8'h70);
      end
      ld_valid = 1'b0;
      check("t2_done", {7'd0, ld_done}, 8'h01);
      check("t2_csum", ld_csum, 8'h00);
      check("t2_ready_done", {7'd0, ld_ready}, 8'h00);

      // T3: source holds valid in L_DONE
      ld_valid = 1'b1; ld_data = 8'h99;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t3_ready", {7'd0, ld_ready}, 8'h00);
      end
      ld_valid = 1'b0;
      check("t3_csum", ld_csum, 8'h00);
      check("t3_done", {7'd0, ld_done}, 8'h01);
      ld_mode = 1'b0;
      tick();
      check("t3_done_clr", {7'd0, ld_done}, 8'h00);
      cpu_read("t2_m0", 8'h00, 8'h61);
      cpu_read("t2_m1", 8'h01, 8'h0F);
      cpu_read("t2_m2", 8'h02, 8'h70);
      cpu_read("t2_m3", 8'h03, 8'h20);
      cpu_read("t3_m4", 8'h04, 8'h33);

      // T4: cpu access while loader owns memory
      ld_mode = 1'b1;
      En = 1'b1; Rw = 1'b0; addr = 8'h00; wdata = 8'hFF;
      tick();
      check("t4_buserr", {7'd0, bus_err}, 8'h01);
      check("t4_rvalid_wr", {7'd0, rvalid}, 8'h00);
      Rw = 1'b1;
      tick();
      En = 1'b0;
      check("t4_rvalid_rd", {7'd0, rvalid}, 8'h00);
      ld_mode = 1'b0;
      tick();
      check("t4_buserr_sticky", {7'd0, bus_err}, 8'h01);
      cpu_read("t4_m0", 8'h00, 8'h61);

      // T5: abort after two bytes
      ld_mode = 1'b1;
      tick();
      send(8'h11);
      send(8'h22);
      ld_mode = 1'b0;
      tick();
      check("t5_done", {7'd0, ld_done}, 8'h00);
      check("t5_csum", ld_csum, 8'h33);
      check("t5_ready", {7'd0, ld_ready}, 8'h00);
      cpu_read("t5_m0", 8'h00, 8'h11);
      cpu_read("t5_m1", 8'h01, 8'h22);
      cpu_read("t5_m2", 8'h02, 8'h70);

      // T6: async reset between edges, then a fresh session from address 0
      ld_mode = 1'b1;
      tick();
      send(8'hAA);
      send(8'hBB);
      check("t6_csum_pre", ld_csum, 8'h65);
      #2;
      rst = 1'b0; ld_mode = 1'b0;
      #1;
      check("t6_ready", {7'd0, ld_ready}, 8'h00);
      check("t6_done", {7'd0, ld_done}, 8'h00);
      check("t6_csum", ld_csum, 8'h00);
      check("t6_buserr", {7'd0, bus_err}, 8'h00);
      tick();
      rst = 1'b1;
      tick();
      ld_mode = 1'b1;
      tick();
      send(8'h01);
      check("t6_csum_new", ld_csum, 8'h01);
      ld_mode = 1'b0;
      tick();
      cpu_read("t6_m0", 8'h00, 8'h01);
      cpu_read("t6_m1", 8'h01, 8'hBB);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
